// File: rtl/button_conditioner.sv
// Pushbutton conditioner: 2-flop sync, ms debounce, press/release pulses
// and optional long-press auto-repeat, one independent FSM per channel.
module button_conditioner #(
   parameter int CLK_FREQ        = 100_000_000,
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_MS     = 20,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_tick
);

   localparam int DIV = CLK_FREQ / 1000;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int M1  = (DEBOUNCE_MS > REPEAT_DELAY_MS) ?
                        DEBOUNCE_MS : REPEAT_DELAY_MS;
   localparam int MAXMS = (M1 > REPEAT_RATE_MS) ? M1 : REPEAT_RATE_MS;
   localparam int CW  = $clog2(MAXMS + 1);

   localparam logic [PW-1:0] P_TOP  = PW'(DIV - 1);
   localparam logic [CW-1:0] DB_END = CW'(DEBOUNCE_MS - 1);
   localparam logic [CW-1:0] RD_END = CW'(REPEAT_DELAY_MS - 1);
   localparam logic [CW-1:0] RR_END = CW'(REPEAT_RATE_MS - 1);

   typedef enum logic [2:0] {
      IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB
   } state_t;

   logic [N_BTN-1:0] meta;
   logic [N_BTN-1:0] sync;
   logic [PW-1:0]    pre;
   logic             ms_tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= btn_in;
         sync <= meta;
      end
   end

   assign ms_tick = (pre == P_TOP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        pre <= '0;
      else if (ms_tick) pre <= '0;
      else              pre <= pre + 1'b1;
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      state_t        state;
      logic [CW-1:0] cnt;
      logic          level_q;
      logic          press_q;
      logic          release_q;
      logic          tick_q;

      // The sync check comes first in every state so an edge always beats
      // a coincident terminal ms_tick.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            tick_q    <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            tick_q    <= 1'b0;
            unique case (state)
               IDLE: begin
                  if (sync[g]) begin
                     state <= PRESS_DB;
                     cnt   <= '0;
                  end
               end
               PRESS_DB: begin
                  if (!sync[g]) begin
                     state <= IDLE;
                  end else if (ms_tick) begin
                     if (cnt == DB_END) begin
                        state   <= HELD;
                        cnt     <= '0;
                        press_q <= 1'b1;
                        tick_q  <= 1'b1;
                        level_q <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               HELD: begin
                  if (!sync[g]) begin
                     state <= RELEASE_DB;
                     cnt   <= '0;
                  end else if (!repeat_en[g]) begin
                     cnt <= '0;
                  end else if (ms_tick) begin
                     if (cnt == RD_END) begin
                        state  <= REPEAT;
                        cnt    <= '0;
                        tick_q <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               REPEAT: begin
                  if (!sync[g]) begin
                     state <= RELEASE_DB;
                     cnt   <= '0;
                  end else if (!repeat_en[g]) begin
                     state <= HELD;
                     cnt   <= '0;
                  end else if (ms_tick) begin
                     if (cnt == RR_END) begin
                        cnt    <= '0;
                        tick_q <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               RELEASE_DB: begin
                  if (sync[g]) begin
                     state <= HELD;
                     cnt   <= '0;
                  end else if (ms_tick) begin
                     if (cnt == DB_END) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign btn_level[g]   = level_q;
      assign btn_press[g]   = press_q;
      assign btn_release[g] = release_q;
      assign btn_tick[g]    = tick_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at 10 cycles per ms,
// debounce 3 ms, repeat delay 5 ms, repeat rate 2 ms.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn_in;
   logic [3:0] repeat_en;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic [3:0] btn_tick;

   button_conditioner #(
      .CLK_FREQ(10_000),
      .N_BTN(4),
      .DEBOUNCE_MS(3),
      .REPEAT_DELAY_MS(5),
      .REPEAT_RATE_MS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_in(btn_in),
      .repeat_en(repeat_en),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .btn_tick(btn_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int pc[4], rc[4], tc[4], fp[4], lh[4], la[4];
   int both;
   int tq[$];
   int c0, c1;

   task automatic clear();
      for (int i = 0; i < 4; i++) begin
         pc[i] = 0; rc[i] = 0; tc[i] = 0;
         fp[i] = -1; lh[i] = 0; la[i] = 0;
      end
      both = 0;
      tq.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (btn_press[i]) begin
            pc[i]++;
            if (fp[i] < 0) fp[i] = cyc;
         end
         if (btn_release[i]) rc[i]++;
         if (btn_tick[i]) tc[i]++;
         if (btn_level[i]) lh[i]++;
         else if (fp[i] >= 0) la[i]++;
         if (btn_press[i] && btn_release[i]) both++;
      end
      if (btn_tick[0]) tq.push_back(cyc);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic rng(input string tag, input int v,
                      input int lo, input int hi);
      checks++;
      assert (v >= lo && v <= hi) passed++;
      else $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
   endtask

   initial begin
      reset = 1'b1;
      btn_in = '0;
      repeat_en = '0;
      clear();
      run(3);
      chk("rst_level", int'(btn_level), 0);
      chk("rst_press", int'(btn_press), 0);
      chk("rst_release", int'(btn_release), 0);
      chk("rst_tick", int'(btn_tick), 0);
      reset = 1'b0;
      run(5);

      // clean press and release on channel 0
      clear();
      btn_in[0] = 1'b1;
      c0 = cyc;
      run(200);
      chk("p1_level_held", int'(btn_level[0]), 1);
      btn_in[0] = 1'b0;
      c1 = cyc;
      run(200);
      chk("p1_press_cnt", pc[0], 1);
      chk("p1_tick_cnt", tc[0], 1);
      rng("p1_press_lat", fp[0] - c0, 22, 33);
      chk("p1_rel_cnt", rc[0], 1);
      chk("p1_level_hi_cycles_ok", int'(lh[0] >= 160), 1);
      chk("p1_level_after", int'(btn_level[0]), 0);
      chk("p1_others_quiet",
          pc[1] + pc[2] + pc[3] + rc[1] + rc[2] + rc[3] +
          lh[1] + lh[2] + lh[3], 0);

      // bouncing input on channel 1 never settles long enough
      clear();
      for (int k = 0; k < 100; k++) begin
         if (k % 7 == 0) btn_in[1] = ~btn_in[1];
         step();
      end
      btn_in[1] = 1'b0;
      run(60);
      chk("p2_press_cnt", pc[1], 0);
      chk("p2_rel_cnt", rc[1], 0);
      chk("p2_level_hi", lh[1], 0);

      // short release glitch on channel 2 is a bounce
      clear();
      btn_in[2] = 1'b1;
      run(100);
      btn_in[2] = 1'b0;
      run(12);
      btn_in[2] = 1'b1;
      run(100);
      chk("p3_press_cnt", pc[2], 1);
      chk("p3_rel_cnt", rc[2], 0);
      chk("p3_level_drop", la[2], 0);
      btn_in[2] = 1'b0;
      run(60);

      // auto-repeat on channel 0
      clear();
      repeat_en[0] = 1'b1;
      btn_in[0] = 1'b1;
      run(150);
      chk("p4_press_cnt", pc[0], 1);
      chk("p4_tick_cnt", tq.size(), 5);
      if (tq.size() >= 4) begin
         rng("p4_first_repeat", tq[1] - tq[0], 40, 50);
         chk("p4_rate_a", tq[2] - tq[1], 20);
         chk("p4_rate_b", tq[3] - tq[2], 20);
      end else begin
         chk("p4_tick_queue_short", tq.size(), 5);
      end
      repeat_en[0] = 1'b0;
      clear();
      run(100);
      chk("p4_no_repeat", tc[0], 0);
      chk("p4_level_kept", lh[0], 100);

      // async reset while repeating
      repeat_en[0] = 1'b1;
      run(60);
      clear();
      #2;
      reset = 1'b1;
      #1;
      chk("p5_async_level", int'(btn_level), 0);
      chk("p5_async_tick", int'(btn_tick), 0);
      step();
      step();
      chk("p5_rst_rel", rc[0], 0);
      clear();
      reset = 1'b0;
      c0 = cyc;
      run(60);
      chk("p5_repress_cnt", pc[0], 1);
      chk("p5_no_release", rc[0], 0);
      rng("p5_repress_lat", fp[0] - c0, 22, 33);
      btn_in[0] = 1'b0;
      repeat_en[0] = 1'b0;
      run(60);

      // all channels pressed on the same edge
      clear();
      btn_in = 4'b1111;
      run(60);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("p6_press_cnt%0d", i), pc[i], 1);
         chk($sformatf("p6_same_cycle%0d", i), fp[i], fp[0]);
      end
      btn_in = 4'b0000;
      run(60);
      for (int i = 0; i < 4; i++)
         chk($sformatf("p6_rel_cnt%0d", i), rc[i], 1);
      chk("p6_press_and_release", both, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
